ram_arbiter: RTL and testbench

//  - Shares one single-port 256x16 block RAM (ram1) between two requesters, A and B.
//  - Each cycle it grants at most one request using round-robin priority, and drives the RAM port from the winner.
//  - It returns read data to the requester that issued the read, tagged through a read-latency pipeline.
//  - Sits between ram1 and the two datapath masters that use it.

---
 rtl/ram_arb_pkg.sv | 32 +++
 rtl/ram_arb_rr.sv | 26 ++
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types and default widths for the ram_arbiter slice.
//                - AW_DEF / DW_DEF : default address / data widths of ram1
//                - state_t         : arbiter FSM states {CLEAR, RUN}
//                - owner_t         : read-tag owner {OWN_A, OWN_B}
//                - tag_t           : one stage of the read-owner pipeline
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    typedef struct packed {
        logic   vld;
        owner_t own;
    } tag_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_rr
//  Description : Two-way round-robin picker. Purely combinational.
//                A lone request is always granted; on a tie the requester
//                that was NOT granted last time (ptr) wins.
//  Ports       : req_a, req_b  in  request lines
//                ptr           in  owner of the most recent grant
//                gnt_a, gnt_b  out one-hot or zero grant
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t ptr,
    output logic   gnt_a,
    output logic   gnt_b
);

    assign gnt_a = req_a & (~req_b | (ptr == OWN_B));
    assign gnt_b = req_b & (~req_a | (ptr == OWN_A));

endmodule : ram_arb_rr
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one single-port RAM (ram1) between requesters A and B
//                with round-robin arbitration and returns read data to the
//                requester that issued the read via an RD_LAT-deep tag pipe.
//  Ports       : clk, reset_n (sync, active-low)
//                ready                       arbiter accepting requests
//                x_req/x_we/x_addr/x_din     requester x (a, b) command
//                x_gnt                       combinational accept
//                x_rvalid/x_rdata            returned read data
//                ram_we/ram_addr/ram_din     to ram1
//                ram_dout                    from ram1
//  Config      : RAM_ARB_CLEAR_EN - when defined, after reset every RAM
//                location is written with zero (2^AW cycles) before ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
)(
    input  logic          clk,
    input  logic          reset_n,
    output logic          ready,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

`ifdef RAM_ARB_CLEAR_EN
    localparam state_t c_rst_state = CLEAR;
`else
    localparam state_t c_rst_state = RUN;
`endif

    state_t              r_state;
    owner_t              r_ptr;
    logic [AW-1:0]       r_last_addr;
    tag_t   [RD_LAT-1:0] r_pipe;
    tag_t   [RD_LAT-1:0] w_pipe_nxt;
    tag_t                w_tag_in;
    tag_t                w_tag_out;
    logic                w_run;
    logic                w_pick_a;
    logic                w_pick_b;
`ifdef RAM_ARB_CLEAR_EN
    logic [AW-1:0]       r_clr_cnt;
    logic                w_clearing;
`endif

    // Outputs are gated by reset_n directly: reset is synchronous, so the
    // registers still hold old values during the first low cycle.
    assign w_run = reset_n & (r_state == RUN);
    assign ready = w_run;

    ram_arb_rr u_rr (
        .req_a (a_req),
        .req_b (b_req),
        .ptr   (r_ptr),
        .gnt_a (w_pick_a),
        .gnt_b (w_pick_b)
    );

    assign a_gnt = w_run & w_pick_a;
    assign b_gnt = w_run & w_pick_b;

`ifdef RAM_ARB_CLEAR_EN
    assign w_clearing = reset_n & (r_state == CLEAR);
`endif

    // RAM port mux. With no grant the address holds its last value.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = r_last_addr;
        ram_din  = '0;
        if (!reset_n) begin
            ram_addr = '0;
`ifdef RAM_ARB_CLEAR_EN
        end else if (w_clearing) begin
            ram_we   = 1'b1;
            ram_addr = r_clr_cnt;
`endif
        end else if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_din;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_din;
        end
    end

    // FSM, round-robin pointer, held address. Pointer resets to B so that
    // A wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_rst_state;
            r_ptr       <= OWN_B;
            r_last_addr <= '0;
`ifdef RAM_ARB_CLEAR_EN
            r_clr_cnt   <= '0;
`endif
        end else begin
            case (r_state)
`ifdef RAM_ARB_CLEAR_EN
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + AW'(1);
                    if (r_clr_cnt == {AW{1'b1}}) begin
                        r_state <= RUN;
                    end
                end
`endif
                RUN:     r_state <= RUN;
                default: r_state <= RUN;
            endcase

            if (a_gnt) begin
                r_ptr <= OWN_A;
            end else if (b_gnt) begin
                r_ptr <= OWN_B;
            end

            r_last_addr <= ram_addr;
        end
    end

    // Read-owner tag pipeline: stage 0 is loaded in the grant cycle, so the
    // last stage is valid exactly RD_LAT cycles later, aligned with ram_dout.
    assign w_tag_in.vld = (a_gnt & ~a_we) | (b_gnt & ~b_we);
    assign w_tag_in.own = b_gnt ? OWN_B : OWN_A;

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign w_pipe_nxt = w_tag_in;
        end else begin : g_latn
            assign w_pipe_nxt = {r_pipe[RD_LAT-2:0], w_tag_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= w_pipe_nxt;
        end
    end

    assign w_tag_out = r_pipe[RD_LAT-1];

    // Gating with reset_n drops a read whose return cycle coincides with reset.
    assign a_rvalid = reset_n & w_tag_out.vld & (w_tag_out.own == OWN_A);
    assign b_rvalid = reset_n & w_tag_out.vld & (w_tag_out.own == OWN_B);
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed self-checking bench for ram_arbiter with a
//                behavioural 256x16 RAM (read latency 1).
//                Honours RAM_ARB_CLEAR_EN for the post-reset clear sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int RD_LAT = 1;

`ifdef RAM_ARB_CLEAR_EN
    localparam int          c_clear_cycles = 256;
    localparam logic [15:0] c_ff_after_rst = 16'h0000;
`else
    localparam int          c_clear_cycles = 0;
    localparam logic [15:0] c_ff_after_rst = 16'hFFFF;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ready;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din, b_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ready    (ready),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // ram1 model: synchronous write, registered read (latency 1)
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus just after the edge, return at the negedge.
    task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [15:0] ad,
                         input logic br, input logic bw, input logic [7:0] ba, input logic [15:0] bd);
        @(posedge clk);
        #1;
        a_req = ar; a_we = aw; a_addr = aa; a_din = ad;
        b_req = br; b_we = bw; b_addr = ba; b_din = bd;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Count cycles with ready low after reset release (bounded).
    task automatic wait_ready(input int exp_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 2000) begin
`ifdef RAM_ARB_CLEAR_EN
            if (n == 0 || n == 255) begin
                chk("clr_we", {31'd0, ram_we}, 32'd1);
                chk("clr_addr", {24'd0, ram_addr}, n);
                chk("clr_din", {16'd0, ram_din}, 32'd0);
            end
`endif
            n++;
            @(negedge clk);
        end
        chk("ready_delay", n, exp_cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic exp_a;
        logic prev_a;

        reset_n = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h55; a_din = 16'h5A5A;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h66; b_din = 16'h0000;

        // Test 1: outputs while in reset, then release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  {31'd0, ready},    32'd0);
        chk("rst_a_gnt",  {31'd0, a_gnt},    32'd0);
        chk("rst_b_gnt",  {31'd0, b_gnt},    32'd0);
        chk("rst_ram_we", {31'd0, ram_we},   32'd0);
        chk("rst_addr",   {24'd0, ram_addr}, 32'd0);
        chk("rst_din",    {16'd0, ram_din},  32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_din = 16'h0000;
        b_req = 1'b0; b_addr = 8'h00;
        wait_ready(c_clear_cycles);
        chk("rel_ready",    {31'd0, ready},    32'd1);
        chk("rel_a_gnt",    {31'd0, a_gnt},    32'd0);
        chk("rel_b_gnt",    {31'd0, b_gnt},    32'd0);
        chk("rel_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rel_b_rvalid", {31'd0, b_rvalid}, 32'd0);

        // Test 2: A writes 0x1234 @0x10, B reads it back next cycle
        drive(1'b1, 1'b1, 8'h10, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("wr_a_gnt",   {31'd0, a_gnt},    32'd1);
        chk("wr_ram_we",  {31'd0, ram_we},   32'd1);
        chk("wr_addr",    {24'd0, ram_addr}, 32'h10);
        chk("wr_din",     {16'd0, ram_din},  32'h1234);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
        chk("rd_b_gnt",   {31'd0, b_gnt},    32'd1);
        chk("rd_ram_we",  {31'd0, ram_we},   32'd0);
        chk("rd_b_rvalid_early", {31'd0, b_rvalid}, 32'd0);
        idle();
        chk("rd_b_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("rd_b_rdata",  {16'd0, b_rdata},  32'h1234);
        chk("rd_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("idle_addr",   {24'd0, ram_addr}, 32'h10);
        chk("idle_we",     {31'd0, ram_we},   32'd0);
        chk("idle_gnt",    {30'd0, a_gnt, b_gnt}, 32'd0);

        // Test 3: preload, then both read for 6 cycles; expect A,B,A,B,A,B
        drive(1'b1, 1'b1, 8'h20, 16'hAAAA, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h30, 16'hBBBB);
        prev_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 8'h30, 16'h0000);
            exp_a = (i % 2 == 0);
            chk("rr_a_gnt", {31'd0, a_gnt}, {31'd0, exp_a});
            chk("rr_b_gnt", {31'd0, b_gnt}, {31'd0, ~exp_a});
            if (i == 0) begin
                chk("rr_no_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
            end else begin
                chk("rr_a_rvalid", {31'd0, a_rvalid}, {31'd0, prev_a});
                chk("rr_b_rvalid", {31'd0, b_rvalid}, {31'd0, ~prev_a});
                chk("rr_rdata", {16'd0, (prev_a ? a_rdata : b_rdata)},
                    prev_a ? 32'hAAAA : 32'hBBBB);
            end
            prev_a = exp_a;
        end
        idle();
        chk("rr_last_b_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("rr_last_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rr_last_rdata",    {16'd0, b_rdata},  32'hBBBB);

        // Test 4: only B requests for 4 cycles
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h30, 16'h0000);
            chk("bonly_b_gnt", {31'd0, b_gnt}, 32'd1);
            chk("bonly_a_gnt", {31'd0, a_gnt}, 32'd0);
            if (i > 0) chk("bonly_b_rvalid", {31'd0, b_rvalid}, 32'd1);
        end
        idle();
        chk("bonly_last_rvalid", {31'd0, b_rvalid}, 32'd1);

        // Test 5: reset one cycle after an A read is accepted.
        // Last grant was A, so without the pointer reset a tie would go to B.
        drive(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("mid_a_gnt", {31'd0, a_gnt}, 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        a_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid0", {31'd0, a_rvalid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rvalid1", {31'd0, a_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready(c_clear_cycles);
        chk("mid_post_rvalid", {31'd0, a_rvalid}, 32'd0);
        drive(1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 8'h30, 16'h0000);
        chk("tie_a_gnt", {31'd0, a_gnt}, 32'd1);
        chk("tie_b_gnt", {31'd0, b_gnt}, 32'd0);
        idle();
        chk("tie_a_rvalid", {31'd0, a_rvalid}, 32'd1);

        // Test 6: write 0xFFFF @0xFF, reset, read back
        drive(1'b1, 1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("ff_wr_gnt", {31'd0, a_gnt}, 32'd1);
        idle();
        do_reset(2);
        wait_ready(c_clear_cycles);
        chk("ff_ready", {31'd0, ready}, 32'd1);
        drive(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        idle();
        chk("ff_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("ff_rdata",  {16'd0, a_rdata},  {16'd0, c_ff_after_rst});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire
